// File: rtl/tlul_csr_host.sv
// TL-UL host for the access-control CSR port: turns single-word read/write
// commands into Get/PutFullData/PutPartialData requests and returns the
// checked D-channel response, with an optional response timeout.
//
// state  | meaning
// IDLE   | ready for a command
// A_SEND | request held on the A channel until a_ready
// D_WAIT | waiting for the matching D beat, timeout counter running
// RESP   | one-cycle response strobe, source tag advances

package tlul_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_DBW = 4;
  localparam int TL_SZW = 2;

  localparam logic [2:0] PUT_FULL_DATA    = 3'h0;
  localparam logic [2:0] PUT_PARTIAL_DATA = 3'h1;
  localparam logic [2:0] GET              = 3'h4;
  localparam logic [2:0] ACCESS_ACK       = 3'h0;
  localparam logic [2:0] ACCESS_ACK_DATA  = 3'h1;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

module tlul_csr_host #(
  parameter int SRC_W          = 8,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [31:0]        cmd_addr,
  input  logic [31:0]        cmd_wdata,
  input  logic [3:0]         cmd_be,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic               rsp_timeout,
  output logic               busy,
  output tlul_pkg::tl_h2d_t  tl_h2d_o,
  input  tlul_pkg::tl_d2h_t  tl_d2h_i
);
  import tlul_pkg::*;

  typedef enum logic [1:0] {IDLE, A_SEND, D_WAIT, RESP} state_e;

  // Last D_WAIT count before expiry; unused when the timeout is disabled.
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [SRC_W-1:0]  src_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [2:0]        opcode_q;
  logic [31:0]       addr_q;
  logic [31:0]       data_q;
  logic [3:0]        mask_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;
  logic [31:0]       rsp_rdata_q;

  logic              d_ready;
  logic              cmd_hs;
  logic              a_hs;
  logic              d_hs;
  logic              mismatch;
  logic              d_err;
  logic              timeout_hit;

  logic unused_in;
  assign unused_in = ^{cmd_addr[1:0], tl_d2h_i.d_param, tl_d2h_i.d_size,
                       tl_d2h_i.d_sink};

  // D-channel acceptance and response checking.
  always_comb begin
    d_ready     = !rst;
    d_hs        = tl_d2h_i.d_valid && d_ready;
    mismatch    = (tl_d2h_i.d_source != TL_AIW'(src_q)) ||
                  (tl_d2h_i.d_opcode != (we_q ? ACCESS_ACK : ACCESS_ACK_DATA));
    d_err       = tl_d2h_i.d_error || mismatch;
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST) && !d_hs;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and bus/command outputs.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && !rst) state_d = A_SEND;
      end
      A_SEND: if (tl_d2h_i.a_ready) state_d = D_WAIT;
      D_WAIT: if (d_hs || timeout_hit) state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cmd_hs = cmd_valid && cmd_ready;
    a_hs   = (state_q == A_SEND) && tl_d2h_i.a_ready;

    tl_h2d_o           = '0;
    tl_h2d_o.a_valid   = (state_q == A_SEND);
    tl_h2d_o.a_opcode  = opcode_q;
    tl_h2d_o.a_size    = 2'd2;
    tl_h2d_o.a_source  = TL_AIW'(src_q);
    tl_h2d_o.a_address = addr_q;
    tl_h2d_o.a_mask    = mask_q;
    tl_h2d_o.a_data    = data_q;
    tl_h2d_o.d_ready   = d_ready;

    busy        = (state_q != IDLE);
    rsp_valid   = (state_q == RESP);
    rsp_err     = rsp_err_q;
    rsp_timeout = rsp_timeout_q;
    rsp_rdata   = rsp_rdata_q;
  end

  // Command capture, timeout counter, response capture and source tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q         <= '0;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      opcode_q      <= 3'h0;
      addr_q        <= '0;
      data_q        <= '0;
      mask_q        <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      if (cmd_hs) begin
        we_q     <= cmd_we;
        opcode_q <= !cmd_we ? GET :
                    (cmd_be == 4'hF) ? PUT_FULL_DATA : PUT_PARTIAL_DATA;
        addr_q   <= {cmd_addr[31:2], 2'b00};
        mask_q   <= cmd_we ? cmd_be : 4'hF;
        data_q   <= cmd_we ? cmd_wdata : 32'h0;
      end

      if (a_hs)                   cnt_q <= '0;
      else if (state_q == D_WAIT) cnt_q <= cnt_q + 1'b1;

      if (state_q == D_WAIT) begin
        if (d_hs) begin
          rsp_err_q     <= d_err;
          rsp_timeout_q <= 1'b0;
          rsp_rdata_q   <= (!we_q && !d_err) ? tl_d2h_i.d_data : 32'h0;
        end else if (timeout_hit) begin
          rsp_err_q     <= 1'b1;
          rsp_timeout_q <= 1'b1;
          rsp_rdata_q   <= 32'h0;
        end
      end

      if (state_q == RESP) src_q <= src_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_tlul_csr_host.sv
// Directed bench for tlul_csr_host with an 8-cycle response timeout.
module tb_tlul_csr_host;
  import tlul_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  tl_h2d_t     h2d;
  tl_d2h_t     d2h;

  int n_chk  = 0;
  int n_fail = 0;

  tlul_csr_host #(.SRC_W(8), .TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .tl_h2d_o(h2d), .tl_d2h_i(d2h)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be;
  endtask

  task automatic dbeat(input logic [2:0] op, input logic [7:0] src, input logic [31:0] data,
                       input logic err);
    d2h.d_valid = 1'b1; d2h.d_opcode = op; d2h.d_source = src;
    d2h.d_data = data; d2h.d_error = err;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
    d2h = '0;
    tick(); tick();
    chk("rst_a_valid", 32'(h2d.a_valid), 32'h0);
    chk("rst_d_ready", 32'(h2d.d_ready), 32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_a_source", 32'(h2d.a_source), 32'h0);
    rst = 1'b0; #1;
    chk("idle_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("idle_d_ready", 32'(h2d.d_ready), 32'h1);

    // Full-word write, immediate a_ready and first-cycle AccessAck.
    d2h.a_ready = 1'b1;
    cmd(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF);
    tick(); cmd_valid = 1'b0;
    chk("w1_a_valid", 32'(h2d.a_valid), 32'h1);
    chk("w1_opcode", 32'(h2d.a_opcode), 32'h0);
    chk("w1_mask", 32'(h2d.a_mask), 32'hF);
    chk("w1_source", 32'(h2d.a_source), 32'h0);
    chk("w1_addr", h2d.a_address, 32'h1000);
    chk("w1_data", h2d.a_data, 32'hDEADBEEF);
    chk("w1_size", 32'(h2d.a_size), 32'h2);
    chk("w1_busy", 32'(busy), 32'h1);
    chk("w1_cmd_ready", 32'(cmd_ready), 32'h0);
    tick();
    chk("w1_a_drop", 32'(h2d.a_valid), 32'h0);
    chk("w1_no_rsp_yet", 32'(rsp_valid), 32'h0);
    dbeat(ACCESS_ACK, 8'd0, 32'h0, 1'b0);
    tick(); d2h.d_valid = 1'b0;
    chk("w1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("w1_rsp_err", 32'(rsp_err), 32'h0);
    chk("w1_rsp_timeout", 32'(rsp_timeout), 32'h0);
    chk("w1_rsp_rdata", rsp_rdata, 32'h0);
    tick();
    chk("w1_rsp_one_cycle", 32'(rsp_valid), 32'h0);
    chk("w1_back_idle", 32'(cmd_ready), 32'h1);

    // Read with 5 stalled a_ready cycles; A fields must hold.
    d2h.a_ready = 1'b0;
    cmd(1'b0, 32'h1006, 32'hFFFFFFFF, 4'h1);
    tick(); cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      chk("r1_stall_valid", 32'(h2d.a_valid), 32'h1);
      chk("r1_stall_opcode", 32'(h2d.a_opcode), 32'h4);
      chk("r1_stall_addr", h2d.a_address, 32'h1004);
      chk("r1_stall_mask", 32'(h2d.a_mask), 32'hF);
      chk("r1_stall_data", h2d.a_data, 32'h0);
      chk("r1_stall_source", 32'(h2d.a_source), 32'h1);
      tick();
    end
    chk("r1_still_valid", 32'(h2d.a_valid), 32'h1);
    d2h.a_ready = 1'b1;
    tick();
    dbeat(ACCESS_ACK_DATA, 8'd1, 32'h12345678, 1'b0);
    tick(); d2h.d_valid = 1'b0;
    chk("r1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("r1_rsp_rdata", rsp_rdata, 32'h12345678);
    chk("r1_rsp_err", 32'(rsp_err), 32'h0);
    tick();
    chk("r1_rdata_hold", rsp_rdata, 32'h12345678);

    // Partial write answered with d_error.
    cmd(1'b1, 32'h2000, 32'hA5A5A5A5, 4'h3);
    tick(); cmd_valid = 1'b0;
    chk("w2_opcode", 32'(h2d.a_opcode), 32'h1);
    chk("w2_mask", 32'(h2d.a_mask), 32'h3);
    chk("w2_source", 32'(h2d.a_source), 32'h2);
    tick();
    dbeat(ACCESS_ACK, 8'd2, 32'h0, 1'b1);
    tick(); d2h.d_valid = 1'b0;
    chk("w2_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("w2_rsp_err", 32'(rsp_err), 32'h1);
    chk("w2_rsp_timeout", 32'(rsp_timeout), 32'h0);
    tick();

    // Read answered with the wrong source tag.
    cmd(1'b0, 32'h3000, 32'h0, 4'h0);
    tick(); cmd_valid = 1'b0;
    chk("r2_source", 32'(h2d.a_source), 32'h3);
    tick();
    dbeat(ACCESS_ACK_DATA, 8'd4, 32'hCAFEF00D, 1'b0);
    tick(); d2h.d_valid = 1'b0;
    chk("r2_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("r2_rsp_err", 32'(rsp_err), 32'h1);
    chk("r2_rsp_rdata", rsp_rdata, 32'h0);
    tick();

    // Read answered with the wrong opcode.
    cmd(1'b0, 32'h3004, 32'h0, 4'h0);
    tick(); cmd_valid = 1'b0;
    tick();
    dbeat(ACCESS_ACK, 8'd4, 32'h11112222, 1'b0);
    tick(); d2h.d_valid = 1'b0;
    chk("r3_rsp_err", 32'(rsp_err), 32'h1);
    chk("r3_rsp_rdata", rsp_rdata, 32'h0);
    tick();

    // Timeout: no D response, then a late AccessAck that must be dropped.
    cmd(1'b0, 32'h4000, 32'h0, 4'h0);
    tick(); cmd_valid = 1'b0;
    chk("to_source", 32'(h2d.a_source), 32'h5);
    tick();
    for (int i = 0; i < 7; i++) begin
      chk("to_wait_no_rsp", 32'(rsp_valid), 32'h0);
      chk("to_wait_busy", 32'(busy), 32'h1);
      tick();
    end
    chk("to_wait_last", 32'(rsp_valid), 32'h0);
    tick();
    chk("to_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("to_rsp_err", 32'(rsp_err), 32'h1);
    chk("to_rsp_timeout", 32'(rsp_timeout), 32'h1);
    chk("to_rsp_rdata", rsp_rdata, 32'h0);
    tick();
    chk("to_rsp_drop", 32'(rsp_valid), 32'h0);
    tick(); tick();
    dbeat(ACCESS_ACK, 8'd5, 32'h0, 1'b0);
    tick(); d2h.d_valid = 1'b0;
    chk("late_no_rsp", 32'(rsp_valid), 32'h0);
    chk("late_idle_busy", 32'(busy), 32'h0);
    chk("late_idle_ready", 32'(cmd_ready), 32'h1);
    chk("late_timeout_hold", 32'(rsp_timeout), 32'h1);
    tick();
    chk("late_still_no_rsp", 32'(rsp_valid), 32'h0);

    // Reset while in D_WAIT.
    cmd(1'b1, 32'h5000, 32'h55AA55AA, 4'hF);
    tick(); cmd_valid = 1'b0;
    chk("rstm_source", 32'(h2d.a_source), 32'h6);
    tick();
    chk("rstm_busy_pre", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    chk("rstm_a_valid", 32'(h2d.a_valid), 32'h0);
    chk("rstm_busy", 32'(busy), 32'h0);
    chk("rstm_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rstm_cmd_ready_in_rst", 32'(cmd_ready), 32'h0);
    chk("rstm_rsp_timeout", 32'(rsp_timeout), 32'h0);
    rst = 1'b0; #1;
    chk("rstm_cmd_ready", 32'(cmd_ready), 32'h1);
    tick();
    chk("rstm_no_rsp_after", 32'(rsp_valid), 32'h0);

    // Back-to-back reads, source tag wraps after 255.
    for (int i = 0; i < 257; i++) begin
      cmd(1'b0, 32'(i * 4), 32'h0, 4'h0);
      tick(); cmd_valid = 1'b0;
      chk("seq_source", 32'(h2d.a_source), 32'(i % 256));
      tick();
      dbeat(ACCESS_ACK_DATA, 8'(i % 256), 32'h5A5A0000 ^ 32'(i), 1'b0);
      tick(); d2h.d_valid = 1'b0;
      chk("seq_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("seq_rsp_err", 32'(rsp_err), 32'h0);
      chk("seq_rsp_rdata", rsp_rdata, 32'h5A5A0000 ^ 32'(i));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
